// File: rtl/apb_master_if.sv
// rtl/apb_master_if.sv - command/response port and APB bus bundle for apb_master
interface apb_master_if #(
    parameter int DATA_SIZE  = 32,
    parameter int ADDR_SIZE  = 32,
    parameter int PSTRB_SIZE = DATA_SIZE / 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_SIZE-1:0]  cmd_addr;
    logic [DATA_SIZE-1:0]  cmd_wdata;
    logic [PSTRB_SIZE-1:0] cmd_pstrb;
    logic                  rsp_valid;
    logic [DATA_SIZE-1:0]  rsp_rdata;
    logic                  rsp_err;
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_SIZE-1:0]  paddr;
    logic [DATA_SIZE-1:0]  pwdata;
    logic [PSTRB_SIZE-1:0] pstrb;
    logic [DATA_SIZE-1:0]  prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_pstrb,
        input  prdata, pready, pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output psel, penable, pwrite, paddr, pwdata, pstrb
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_pstrb,
        output prdata, pready, pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  psel, penable, pwrite, paddr, pwdata, pstrb
    );
endinterface

// File: rtl/apb_master.sv
// rtl/apb_master.sv - APB requester bridging a command/response port onto APB
// Optional ACCESS-phase timeout is built when APB_MASTER_TIMEOUT_EN is defined.
module apb_master #(
    parameter int DATA_SIZE      = 32,
    parameter int ADDR_SIZE      = 32,
    parameter int PSTRB_SIZE     = DATA_SIZE / 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic          pclk,
    input  logic          prst,
    apb_master_if.master  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                state;
    state_t                state_d;
    logic                  accept;
    logic                  xfer_ok;
    logic                  xfer_timeout;
    logic                  cmd_ready_q;
    logic                  psel_q;
    logic                  penable_q;
    logic                  pwrite_q;
    logic                  rsp_valid_q;
    logic                  rsp_err_q;
    logic [ADDR_SIZE-1:0]  paddr_q;
    logic [DATA_SIZE-1:0]  pwdata_q;
    logic [DATA_SIZE-1:0]  rdata_q;
    logic [PSTRB_SIZE-1:0] pstrb_q;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("apb_master: TIMEOUT_CYCLES must be at least 2");
    end

    assign accept = (state == IDLE) && cmd_ready_q && bus.cmd_valid;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] tmo_cnt;

    // Held at zero outside ACCESS so every ACCESS phase starts counting from 0.
    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            tmo_cnt <= '0;
        end else if (state != ACCESS) begin
            tmo_cnt <= '0;
        end else if (!bus.pready) begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
    end
`endif

    always_comb begin
        state_d      = state;
        xfer_ok      = 1'b0;
        xfer_timeout = 1'b0;
        case (state)
            IDLE:   if (accept) state_d = SETUP;
            SETUP:  state_d = ACCESS;
            ACCESS: begin
                if (bus.pready) begin
                    xfer_ok = 1'b1;
                    state_d = DONE;
                end
`ifdef APB_MASTER_TIMEOUT_EN
                else if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    xfer_timeout = 1'b1;
                    state_d      = DONE;
                end
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Outputs are decoded from the next state so they are registered yet line up with it.
    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            cmd_ready_q <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            rdata_q     <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            cmd_ready_q <= (state_d == IDLE);
            psel_q      <= (state_d == SETUP) || (state_d == ACCESS);
            penable_q   <= (state_d == ACCESS);
            rsp_valid_q <= (state_d == DONE);
            if (accept) begin
                pwrite_q <= bus.cmd_write;
                paddr_q  <= bus.cmd_addr;
                pwdata_q <= bus.cmd_write ? bus.cmd_wdata : '0;
                pstrb_q  <= bus.cmd_write ? bus.cmd_pstrb : '0;
            end
            if (xfer_ok) begin
                rdata_q   <= pwrite_q ? '0 : bus.prdata;
                rsp_err_q <= bus.pslverr;
            end else if (xfer_timeout) begin
                rdata_q   <= '0;
                rsp_err_q <= 1'b1;
            end
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.psel      = psel_q;
    assign bus.penable   = penable_q;
    assign bus.pwrite    = pwrite_q;
    assign bus.paddr     = paddr_q;
    assign bus.pwdata    = pwdata_q;
    assign bus.pstrb     = pstrb_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - randomized self-checking bench for apb_master
module tb_apb_master;
    localparam int TMO = 16;

    typedef struct {
        logic        got;
        int          lat;
        int          acc;
        int          unstable;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] rdata;
        logic        err;
    } obs_t;

    logic pclk = 1'b0;
    logic prst;
    int   checks = 0;
    int   errors = 0;

    apb_master_if #(.DATA_SIZE(32), .ADDR_SIZE(32), .PSTRB_SIZE(4)) bus ();

    apb_master #(
        .DATA_SIZE(32), .ADDR_SIZE(32), .PSTRB_SIZE(4), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .pclk(pclk),
        .prst(prst),
        .bus (bus)
    );

    always #5 pclk = ~pclk;

    // Expected outcome of one transfer from the protocol rules alone.
    function automatic obs_t model(input logic w, input logic [31:0] a, input logic [31:0] d,
                                   input logic [3:0] s, input int waits, input logic [31:0] rd,
                                   input logic serr);
        obs_t e;
        e.got      = 1'b1;
        e.unstable = 0;
        e.write    = w;
        e.addr     = a;
        e.wdata    = w ? d : 32'h0;
        e.strb     = w ? s : 4'h0;
`ifdef APB_MASTER_TIMEOUT_EN
        if (waits >= TMO) begin
            e.acc   = TMO;
            e.lat   = 2 + TMO;
            e.rdata = 32'h0;
            e.err   = 1'b1;
            return e;
        end
`endif
        e.acc   = waits + 1;
        e.lat   = 3 + waits;
        e.rdata = w ? 32'h0 : rd;
        e.err   = serr;
        return e;
    endfunction

    // Issues one command and plays an APB slave that raises pready on ACCESS cycle waits+1.
    task automatic do_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int waits, input logic [31:0] rd,
                           input logic serr, input int max_cycles, output obs_t o);
        int wait_rdy = 0;
        o = '{got: 1'b0, lat: 0, acc: 0, unstable: 0, write: 1'b0, addr: 32'h0,
              wdata: 32'h0, strb: 4'h0, rdata: 32'h0, err: 1'b0};
        @(negedge pclk);
        while (!bus.cmd_ready && wait_rdy < 20) begin
            @(negedge pclk);
            wait_rdy++;
        end
        if (!bus.cmd_ready) return;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        bus.cmd_pstrb = s;
        for (int i = 1; i <= max_cycles; i++) begin
            @(negedge pclk);
            bus.cmd_valid = 1'b0;
            bus.cmd_write = 1'($urandom);
            bus.cmd_addr  = $urandom;
            bus.cmd_wdata = $urandom;
            bus.cmd_pstrb = 4'($urandom);
            if (bus.rsp_valid) begin
                o.got   = 1'b1;
                o.lat   = i;
                o.rdata = bus.rsp_rdata;
                o.err   = bus.rsp_err;
                break;
            end
            if (bus.psel && !bus.penable) begin
                o.write = bus.pwrite;
                o.addr  = bus.paddr;
                o.wdata = bus.pwdata;
                o.strb  = bus.pstrb;
            end else if (bus.psel && bus.penable) begin
                o.acc++;
                if (bus.paddr !== o.addr || bus.pwrite !== o.write ||
                    bus.pwdata !== o.wdata || bus.pstrb !== o.strb) o.unstable++;
            end
            if (bus.psel && bus.penable) begin
                bus.pready  = (o.acc == waits + 1);
                bus.prdata  = bus.pready ? rd : $urandom;
                bus.pslverr = bus.pready ? serr : 1'($urandom);
            end else begin
                bus.pready  = 1'($urandom);
                bus.prdata  = $urandom;
                bus.pslverr = 1'($urandom);
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge pclk);
        checks++;
        if ({bus.cmd_ready, bus.psel, bus.penable, bus.pwrite, bus.rsp_valid, bus.rsp_err,
             bus.paddr, bus.pwdata, bus.pstrb, bus.rsp_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got psel=%b penable=%b cmd_ready=%b rsp_valid=%b paddr=%h exp all 0",
                     bus.psel, bus.penable, bus.cmd_ready, bus.rsp_valid, bus.paddr);
        end
        prst = 1'b0;
        @(negedge pclk);
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_cmd_ready got %b exp 1", bus.cmd_ready);
        end
    endtask

    task automatic test_write_zero_wait();
        obs_t o;
        do_xfer(1'b1, 32'h4, 32'hA5A5_0001, 4'hF, 0, $urandom, 1'b0, 50, o);
        checks++; if (o.got !== 1'b1) begin errors++; $display("FAIL wr_got_rsp got %b exp 1", o.got); end
        checks++; if (o.lat !== 3) begin errors++; $display("FAIL wr_latency got %0d exp 3", o.lat); end
        checks++; if (o.acc !== 1) begin errors++; $display("FAIL wr_access_cycles got %0d exp 1", o.acc); end
        checks++;
        if ({o.write, o.addr, o.wdata, o.strb} !== {1'b1, 32'h4, 32'hA5A5_0001, 4'hF}) begin
            errors++;
            $display("FAIL wr_bus got w=%b a=%h d=%h s=%h exp w=1 a=4 d=a5a50001 s=f", o.write, o.addr, o.wdata, o.strb);
        end
        checks++; if (o.err !== 1'b0) begin errors++; $display("FAIL wr_err got %b exp 0", o.err); end
        checks++; if (o.rdata !== 32'h0) begin errors++; $display("FAIL wr_rdata got %h exp 0", o.rdata); end
    endtask

    task automatic test_read_wait();
        obs_t o;
        do_xfer(1'b0, 32'h8, $urandom, 4'hF, 3, 32'h1234_5678, 1'b0, 50, o);
        checks++; if (o.lat !== 6) begin errors++; $display("FAIL rd_latency got %0d exp 6", o.lat); end
        checks++; if (o.acc !== 4) begin errors++; $display("FAIL rd_access_cycles got %0d exp 4", o.acc); end
        checks++; if (o.rdata !== 32'h1234_5678) begin errors++; $display("FAIL rd_rdata got %h exp 12345678", o.rdata); end
        checks++;
        if (o.strb !== 4'h0 || o.wdata !== 32'h0 || o.unstable !== 0) begin
            errors++;
            $display("FAIL rd_pstrb got s=%h d=%h unstable=%0d exp s=0 d=0 unstable=0", o.strb, o.wdata, o.unstable);
        end
    endtask

    task automatic test_slave_error();
        obs_t o;
        do_xfer(1'b1, $urandom, $urandom, 4'h3, $urandom_range(0, 2), $urandom, 1'b1, 50, o);
        checks++; if (o.err !== 1'b1) begin errors++; $display("FAIL slverr_err got %b exp 1", o.err); end
        do_xfer(1'b0, $urandom, $urandom, 4'h0, 1, 32'hCAFE_0042, 1'b0, 50, o);
        checks++; if (o.err !== 1'b0) begin errors++; $display("FAIL slverr_next_err got %b exp 0", o.err); end
        checks++; if (o.rdata !== 32'hCAFE_0042) begin errors++; $display("FAIL slverr_next_rdata got %h exp cafe0042", o.rdata); end
    endtask

    task automatic test_random();
        obs_t o, e;
        logic w, serr;
        logic [31:0] a, d, rd;
        logic [3:0] s;
        int waits;
        for (int i = 0; i < 40; i++) begin
            w = 1'($urandom); a = $urandom; d = $urandom; rd = $urandom;
            s = 4'($urandom); serr = 1'($urandom); waits = $urandom_range(0, 6);
            e = model(w, a, d, s, waits, rd, serr);
            do_xfer(w, a, d, s, waits, rd, serr, 60, o);
            checks++; if (o.got !== e.got || o.lat !== e.lat) begin errors++; $display("FAIL rnd%0d_latency got %0d exp %0d", i, o.lat, e.lat); end
            checks++; if (o.acc !== e.acc) begin errors++; $display("FAIL rnd%0d_access got %0d exp %0d", i, o.acc, e.acc); end
            checks++;
            if ({o.write, o.addr, o.wdata, o.strb} !== {e.write, e.addr, e.wdata, e.strb}) begin
                errors++;
                $display("FAIL rnd%0d_bus got w=%b a=%h d=%h s=%h exp w=%b a=%h d=%h s=%h", i,
                         o.write, o.addr, o.wdata, o.strb, e.write, e.addr, e.wdata, e.strb);
            end
            checks++; if (o.unstable !== 0) begin errors++; $display("FAIL rnd%0d_stable got %0d exp 0", i, o.unstable); end
            checks++;
            if (o.rdata !== e.rdata || o.err !== e.err) begin
                errors++;
                $display("FAIL rnd%0d_rsp got rdata=%h err=%b exp rdata=%h err=%b", i, o.rdata, o.err, e.rdata, e.err);
            end
            @(negedge pclk);
            checks++;
            if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== e.rdata || bus.cmd_ready !== 1'b1) begin
                errors++;
                $display("FAIL rnd%0d_hold got rsp_valid=%b rdata=%h cmd_ready=%b exp 0 %h 1",
                         i, bus.rsp_valid, bus.rsp_rdata, bus.cmd_ready, e.rdata);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [2];
        logic [31:0] cur_addr = 32'h0;
        int setup_cyc [$];
        logic [31:0] setup_addr [$];
        int unstable = 0;
        int rsp_cnt = 0;
        addrs[0] = $urandom;
        addrs[1] = $urandom;
        @(negedge pclk);
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = addrs[0];
        bus.cmd_wdata = $urandom; bus.cmd_pstrb = 4'hF;
        bus.pready = 1'b1; bus.pslverr = 1'b0;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            @(negedge pclk);
            if (bus.rsp_valid) rsp_cnt++;
            if (bus.psel && !bus.penable) begin
                setup_cyc.push_back(cyc);
                setup_addr.push_back(bus.paddr);
                cur_addr = bus.paddr;
                bus.cmd_addr  = addrs[1];
                bus.cmd_wdata = $urandom;
                if (setup_cyc.size() == 2) bus.cmd_valid = 1'b0;
            end else if (bus.psel && bus.penable && bus.paddr !== cur_addr) begin
                unstable++;
            end
        end
        bus.cmd_valid = 1'b0;
        checks++; if (setup_cyc.size() !== 2) begin errors++; $display("FAIL b2b_setups got %0d exp 2", setup_cyc.size()); end
        if (setup_cyc.size() == 2) begin
            checks++;
            if (setup_cyc[1] - setup_cyc[0] !== 4) begin
                errors++;
                $display("FAIL b2b_spacing got %0d exp 4", setup_cyc[1] - setup_cyc[0]);
            end
            checks++;
            if (setup_addr[0] !== addrs[0] || setup_addr[1] !== addrs[1]) begin
                errors++;
                $display("FAIL b2b_paddr got %h %h exp %h %h", setup_addr[0], setup_addr[1], addrs[0], addrs[1]);
            end
        end
        checks++; if (unstable !== 0) begin errors++; $display("FAIL b2b_paddr_stable got %0d exp 0", unstable); end
        checks++; if (rsp_cnt !== 2) begin errors++; $display("FAIL b2b_rsp_count got %0d exp 2", rsp_cnt); end
    endtask

    task automatic test_reset_mid_access();
        logic seen_access = 1'b0;
        int rsp_seen = 0;
        @(negedge pclk);
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = $urandom;
        bus.pready = 1'b0; bus.pslverr = 1'b0;
        for (int i = 0; i < 10 && !seen_access; i++) begin
            @(negedge pclk);
            if (bus.psel) bus.cmd_valid = 1'b0;
            if (bus.psel && bus.penable) seen_access = 1'b1;
        end
        bus.cmd_valid = 1'b0;
        checks++; if (seen_access !== 1'b1) begin errors++; $display("FAIL rst_mid_reach_access got %b exp 1", seen_access); end
        #2 prst = 1'b1;
        #1;
        checks++;
        if ({bus.psel, bus.penable} !== 2'b00) begin
            errors++;
            $display("FAIL rst_mid_async_drop got psel=%b penable=%b exp 0 0", bus.psel, bus.penable);
        end
        repeat (3) begin
            @(negedge pclk);
            if (bus.rsp_valid) rsp_seen++;
        end
        prst = 1'b0;
        @(negedge pclk);
        if (bus.rsp_valid) rsp_seen++;
        checks++; if (rsp_seen !== 0) begin errors++; $display("FAIL rst_mid_no_rsp got %0d exp 0", rsp_seen); end
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_cmd_ready got %b exp 1", bus.cmd_ready); end
    endtask

    task automatic test_timeout();
        obs_t o, e;
        logic [31:0] a;
        a = $urandom;
`ifdef APB_MASTER_TIMEOUT_EN
        e = model(1'b0, a, 32'h0, 4'h0, 1000, 32'hDEAD_BEEF, 1'b0);
        do_xfer(1'b0, a, 32'h0, 4'h0, 1000, 32'hDEAD_BEEF, 1'b0, 200, o);
        checks++; if (o.got !== 1'b1 || o.acc !== e.acc) begin errors++; $display("FAIL tmo_access got got=%b acc=%0d exp 1 %0d", o.got, o.acc, e.acc); end
        checks++; if (o.lat !== e.lat) begin errors++; $display("FAIL tmo_latency got %0d exp %0d", o.lat, e.lat); end
        checks++; if (o.err !== 1'b1 || o.rdata !== 32'h0) begin errors++; $display("FAIL tmo_rsp got err=%b rdata=%h exp 1 0", o.err, o.rdata); end
        e = model(1'b0, a, 32'h0, 4'h0, TMO - 1, 32'h0BAD_F00D, 1'b0);
        do_xfer(1'b0, a, 32'h0, 4'h0, TMO - 1, 32'h0BAD_F00D, 1'b0, 200, o);
        checks++;
        if (o.err !== e.err || o.rdata !== e.rdata || o.acc !== e.acc) begin
            errors++;
            $display("FAIL tmo_edge_pready got err=%b rdata=%h acc=%0d exp %b %h %0d", o.err, o.rdata, o.acc, e.err, e.rdata, e.acc);
        end
`else
        do_xfer(1'b0, a, 32'h0, 4'h0, 1000, 32'hDEAD_BEEF, 1'b0, 100, o);
        checks++; if (o.got !== 1'b0) begin errors++; $display("FAIL no_tmo_rsp got %b exp 0", o.got); end
        checks++; if (o.acc !== 99) begin errors++; $display("FAIL no_tmo_access got %0d exp 99", o.acc); end
        @(negedge pclk);
        prst = 1'b1;
        @(negedge pclk);
        prst = 1'b0;
        @(negedge pclk);
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL no_tmo_recover got %b exp 1", bus.cmd_ready); end
`endif
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        prst          = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.cmd_pstrb = '0;
        bus.prdata    = '0;
        bus.pready    = 1'b0;
        bus.pslverr   = 1'b0;
        test_reset();
        test_write_zero_wait();
        test_read_wait();
        test_slave_error();
        test_random();
        test_back_to_back();
        test_reset_mid_access();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
